// File: rtl/phyclk_seq_pkg.sv
// phyclk_seq_pkg: shared types and constants for the PHY clock bring-up
// sequencer.
//   state_e        - 3-bit sequencer state, encodings visible on state_dbg
//   *_DEF          - default cycle counts at a 50 MHz reference clock
//   cw()           - bits needed to hold values 0..v-1 (never less than 1)
//   max2()         - larger of two values, used to size the shared counter
package phyclk_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_PHY_RST   = 3'd3,
    ST_PHY_WAKE  = 3'd4,
    ST_READY     = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  localparam int unsigned PLL_RST_CYCLES_DEF      = 50;      // 1 us
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 500000;  // 10 ms
  localparam int unsigned SETTLE_CYCLES_DEF       = 5000;    // 100 us
  localparam int unsigned PHY_RST_CYCLES_DEF      = 500000;  // 10 ms
  localparam int unsigned PHY_WAKE_CYCLES_DEF     = 250000;  // 5 ms
  localparam int unsigned MAX_RETRIES_DEF         = 7;

  function automatic int unsigned cw(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk    - destination clock
//   rst_n  - synchronous active-low reset, loads RST_VAL into both flops
//   d      - asynchronous input
//   q      - synchronized output, two edges of latency
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/phyclk_bringup_seq.sv
// phyclk_bringup_seq: power-up / recovery sequencer for the Ethernet PHY
// clock domain. Pulses the PLL reset, waits for a stable lock, holds the
// PHY in reset, then releases it and flags eth_ready. Lock timeouts retry
// the PLL up to MAX_RETRIES times before latching fault.
//   clk         - 50 MHz reference clock
//   rst_n       - synchronous active-low reset
//   pll_locked  - PLL lock, asynchronous to clk
//   restart     - single-cycle restart request, beats every other transition
//   pll_rst     - PLL reset, active-high
//   phy_rst_n   - PHY reset, active-low
//   eth_ready   - clocks stable and PHY running
//   fault       - sticky lock failure
//   retry_count - lock attempts consumed
//   state_dbg   - current state encoding
module phyclk_bringup_seq
  import phyclk_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES       = SETTLE_CYCLES_DEF,
  parameter int unsigned PHY_RST_CYCLES      = PHY_RST_CYCLES_DEF,
  parameter int unsigned PHY_WAKE_CYCLES     = PHY_WAKE_CYCLES_DEF,
  parameter int unsigned MAX_RETRIES         = MAX_RETRIES_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pll_locked,
  input  logic                             restart,
  output logic                             pll_rst,
  output logic                             phy_rst_n,
  output logic                             eth_ready,
  output logic                             fault,
  output logic [cw(MAX_RETRIES+1)-1:0]     retry_count,
  output logic [2:0]                       state_dbg
);

  localparam int unsigned CNT_W = cw(max2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                               max2(SETTLE_CYCLES, PHY_RST_CYCLES)),
                                          PHY_WAKE_CYCLES));
  localparam int unsigned RC_W  = cw(MAX_RETRIES + 1);

  // Terminal counter values: a state lasting N cycles leaves when cnt == N-1.
  localparam logic [CNT_W-1:0] PLL_RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_WAKE_LAST = CNT_W'(PHY_WAKE_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX     = RC_W'(MAX_RETRIES);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [RC_W-1:0]   rc_nxt;
  logic              locked_s;
  logic              pll_rst_nxt, phy_rst_n_nxt, eth_ready_nxt, fault_nxt;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_nxt = state;
    rc_nxt    = retry_count;
    if (restart) begin
      state_nxt = ST_PLL_RST;
      rc_nxt    = '0;
    end else begin
      unique case (state)
        ST_PLL_RST:
          if (cnt == PLL_RST_LAST) state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK:
          if (locked_s) state_nxt = ST_SETTLE;
          else if (cnt == LOCK_LAST) begin
            if (retry_count == RETRY_MAX) state_nxt = ST_FAULT;
            else begin
              state_nxt = ST_PLL_RST;
              rc_nxt    = retry_count + RC_W'(1);
            end
          end
        // A dropout while settling only restarts the settle window; the PLL
        // itself did lock, so no retry is charged.
        ST_SETTLE:
          if (!locked_s) state_nxt = ST_WAIT_LOCK;
          else if (cnt == SETTLE_LAST) state_nxt = ST_PHY_RST;
        ST_PHY_RST:
          if (!locked_s) state_nxt = ST_PLL_RST;
          else if (cnt == PHY_RST_LAST) state_nxt = ST_PHY_WAKE;
        ST_PHY_WAKE:
          if (!locked_s) state_nxt = ST_PLL_RST;
          else if (cnt == PHY_WAKE_LAST) begin
            state_nxt = ST_READY;
            rc_nxt    = '0;
          end
        ST_READY:
          if (!locked_s) state_nxt = ST_PLL_RST;
        ST_FAULT: ;
        default: state_nxt = ST_PLL_RST;  // encoding 7 recovers
      endcase
    end

    // restart also clears the counter when it lands in PLL_RST itself.
    cnt_nxt = (restart || state_nxt != state) ? '0 : cnt + CNT_W'(1);

    // Outputs are decoded from the next state so the registers change on the
    // same edge as the state.
    pll_rst_nxt   = (state_nxt == ST_PLL_RST) || (state_nxt == ST_FAULT);
    phy_rst_n_nxt = (state_nxt == ST_PHY_WAKE) || (state_nxt == ST_READY);
    eth_ready_nxt = (state_nxt == ST_READY);
    fault_nxt     = (state_nxt == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_PLL_RST;
      cnt         <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      phy_rst_n   <= 1'b0;
      eth_ready   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_count <= rc_nxt;
      pll_rst     <= pll_rst_nxt;
      phy_rst_n   <= phy_rst_n_nxt;
      eth_ready   <= eth_ready_nxt;
      fault       <= fault_nxt;
    end
  end

  assign state_dbg = state;

endmodule
